// File: rtl/rs232c_tx_pkg.sv
// rs232c_tx_pkg: frame geometry, FSM encoding and default bit period shared with i232c
package rs232c_tx_pkg;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
  localparam int CLKS_PER_BIT_DEF = 143;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;
endpackage

// File: rtl/rs232c_tx_fifo.sv
// tx_byte_fifo: first-word-fall-through byte FIFO with registered full flag
module tx_byte_fifo
  import rs232c_tx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 XRST,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 empty,
  output logic                 full
);
  localparam int CW = DEPTH_LOG2 + 1;
  logic [DATA_BITS-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic we, re;
  // acceptance uses the registered full, so a same-edge pop cannot rescue a write
  assign we = wr_en & ~full;
  assign re = rd_en & ~empty;
  assign empty = count == '0;
  assign rdata = mem[rptr];
  assign count_n = count + CW'(we) - CW'(re);
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      wptr <= wptr + DEPTH_LOG2'(we);
      rptr <= rptr + DEPTH_LOG2'(re);
      count <= count_n;
      full <= count_n == CW'(2**DEPTH_LOG2);
    end
  end
  always_ff @(posedge CLK) begin
    if (we) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/rs232c_tx.sv
// rs232c_tx: buffered 8N1 serial transmitter, back-to-back frames with no idle gap
module rs232c_tx
  import rs232c_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 XRST,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 busy,
  output logic                 tx
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  logic [1:0] state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n, rdata;
  logic tx_n, pop, empty, expire;
  tx_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK(CLK), .XRST(XRST), .wr_en(wr_en), .wdata(data),
    .rd_en(pop), .rdata(rdata), .empty(empty), .full(full)
  );
  assign expire = timer == T_LAST;
  always_comb begin
    state_n = state;
    timer_n = (state == S_IDLE || expire) ? '0 : timer + 1'b1;
    idx_n = idx;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        shift_n = rdata;
        tx_n = 1'b0;
        state_n = S_START;
      end
      S_START: if (expire) begin
        tx_n = shift[0];
        idx_n = '0;
        state_n = S_DATA;
      end
      S_DATA: if (expire) begin
        if (idx == IW'(DATA_BITS - 1)) begin
          tx_n = 1'b1;
          state_n = S_STOP;
        end else begin
          shift_n = shift >> 1;
          tx_n = shift[1];
          idx_n = idx + 1'b1;
        end
      end
      default: if (expire) begin
        if (!empty) begin
          pop = 1'b1;
          shift_n = rdata;
          tx_n = 1'b0;
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end
  // next state is IDLE only with an empty (hence not full) FIFO, so wr_en alone means a byte lands
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state <= S_IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      busy <= (state_n != S_IDLE) | wr_en;
    end
  end
endmodule

// File: doc/rs232c_tx.md
Name: rs232c_tx

Overview:
- Buffered 8N1 serial transmitter. It is the transmit-side counterpart of the existing i232c receiver.
- Core logic pushes bytes into an internal FIFO. The block serialises them onto the RS_TX pin at a fixed bit period.
- It sits in top between the core/IO logic and the RS_TX pad. It is sized so i232c can decode its output in end-to-end simulation.

Parameters:
- CLKS_PER_BIT, 143: clock cycles per serial bit. 143 x 14 ns is about 2000 ns per bit.
- DEPTH_LOG2, 4: log2 of FIFO depth, giving 16 entries.

Ports:
- CLK  in  1  system clock, rising edge.
- XRST  in  1  reset. Asynchronous, active-low.
- data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe, sampled on the rising CLK edge.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- busy  out  1  high when the FIFO is non-empty or a frame is in flight.
- tx  out  1  serial line, idle high.

Behaviour:
- Reset, while XRST=0 (asynchronous): tx=1, full=0, busy=0, FIFO empty, FSM in IDLE, all counters 0. Asserting reset mid-frame aborts the frame, forces tx=1 immediately and discards FIFO contents.
- Outputs: all are registered.
- Enqueue:
  - On an edge with wr_en=1 and full=0, data is written and the count increments.
  - wr_en while full=1 drops the byte silently. No pointer or count change.
  - A write on the same edge as a pop, with count < depth: count unchanged, both take effect.
  - Whether a write is accepted is decided by the registered full value of that cycle. A same-cycle pop does not rescue a write when full=1.
- Frame format: start bit 0, then data[0]..data[7] (LSB first), then stop bit 1. Each bit is held for exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, tx<=0, bit-timer<=0, go to START.
  - START: when the bit-timer reaches CLKS_PER_BIT-1, tx<=shift[0], bit index<=0, go to DATA.
  - DATA: on each timer expiry, shift right and increment the index. After bit 7 expires, tx<=1 and go to STOP.
  - STOP: on timer expiry, if the FIFO is non-empty, pop, tx<=0 and go to START directly. There is no idle gap between frames. Otherwise go to IDLE.
- Latency: a wr_en accepted at edge k into an empty FIFO with the FSM in IDLE gives tx=0 after edge k+1.
- busy rises after the accepting edge. It falls on the edge where STOP expires with the FIFO empty.
- full tracks count==2^DEPTH_LOG2 and is updated on the same edge as the count.
- Width rules:
  - The bit-timer is clog2(CLKS_PER_BIT) bits wide.
  - Pointers are DEPTH_LOG2 bits wide and wrap naturally.
  - The count is DEPTH_LOG2+1 bits wide.
- Constraints: CLKS_PER_BIT >= 2. DEPTH_LOG2 >= 1.

Decomposition:
- Shared package/include holds: state encoding (IDLE/START/DATA/STOP), FRAME_BITS=10, DATA_BITS=8, and the default CLKS_PER_BIT shared with i232c.
- One sub-module: tx_byte_fifo, a synchronous FIFO.
  - Ports: CLK, XRST, wr_en, wdata, rd_en, rdata, empty, full. Parameter DEPTH_LOG2.
  - First-word-fall-through: rdata is valid whenever empty=0.
- The FSM and shifter stay in rs232c_tx.

Test Plan:
- Single byte 0x31 after reset: tx sequence per bit period is 0,1,0,0,0,1,1,0,0,1. Each level is held for exactly 143 cycles. busy=1 for 10*143+1 cycles. tx=0 appears one edge after the write.
- Bytes 49, 48, 0 written on consecutive cycles: no idle cycles between frames. Total line activity is 30*143 cycles. An i232c looped from tx reports changed three times, with data 49, 48, 0.
- Overflow: during the first frame, write 20 bytes 0x00..0x13 on consecutive cycles. The first byte was already popped, so 0x01..0x10 are accepted. full=1 from the edge after 0x10. 0x11..0x13 are dropped. The decoded stream is exactly 0x00..0x10.
- Full/pop boundary: with full=1, pulse wr_en on the edge where STOP pops. The byte is dropped and count becomes depth-1. A write on the next cycle is accepted.
- Reset mid-frame: pull XRST low during DATA bit 3. tx=1 within the same timestep, busy=0, full=0. After release, with no writes, tx stays 1 for 2000 cycles.
- Back-to-back edge: a write arriving exactly on the STOP-expiry edge of an otherwise empty FIFO. The FSM goes to IDLE, then starts the new frame one edge later. tx is high for exactly 1 extra cycle.
